// File: rtl/dlx_alu_pkg.sv
// rtl/dlx_alu_pkg.sv - shared DLX ALU constants and types
package dlx_alu_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div32_seq_if.sv
// rtl/div32_seq_if.sv - start/busy/done handshake between pipeline control and divider
interface div32_seq_if;
  import dlx_alu_pkg::*;

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;

  modport master (
    output start, is_signed, A, B,
    input  busy, done, quot, rem, div_by_zero
  );

  modport slave (
    input  start, is_signed, A, B,
    output busy, done, quot, rem, div_by_zero
  );

endinterface

// File: rtl/div32_step.sv
// rtl/div32_step.sv - one combinational restoring radix-2 division step
module div32_step
  import dlx_alu_pkg::*;
(
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // R < D on entry, so the 33-bit difference is negative exactly when its top bit is set
  assign shifted = {r_i, q_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, d_i};
  assign qbit_o  = ~trial[WIDTH];
  assign r_o     = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_o     = {q_i[WIDTH-2:0], qbit_o};

endmodule

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - multi-cycle signed/unsigned 32-bit restoring divider for DIV/DIVU
module div32_seq
  import dlx_alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  div32_seq_if.slave bus
);

  div_state_t       state_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [4:0]       cnt_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;
  logic             step_qbit_unused;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // 0x80000000 negates to itself and is then treated as an unsigned magnitude
  assign a_mag = (bus.is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign b_mag = (bus.is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // qbit is only needed once the step is unrolled; radix-2 takes it through q_o
  div32_step u_step (
    .r_i    (r_q),
    .q_i    (q_q),
    .d_i    (d_q),
    .r_o    (r_d),
    .q_o    (q_d),
    .qbit_o (step_qbit_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            r_q     <= '0;
            q_q     <= a_mag;
            d_q     <= b_mag;
            cnt_q   <= '0;
            neg_q_q <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_r_q <= bus.is_signed & bus.A[WIDTH-1];
            if (bus.B == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= DIV_ZERO_QUOT;
              rem_q   <= bus.A;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quot_q  <= neg_q_q ? -q_q : q_q;
          rem_q   <= neg_r_q ? -r_q : r_q;
          dbz_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - scoreboard bench for div32_seq with directed vectors
module tb_div32_seq;
  import dlx_alu_pkg::*;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               ec;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  div32_seq_if bus ();

  div32_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   ec = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_lo = 0;
  int   busy_hi = -1;
  int   last_done = -1;
  int   first_done;
  exp_t sb[$];

  always @(posedge clk) ec <= ec + 1;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @ec=%0d: got %h expected %h", name, ec, act, exp);
    end
  endtask

  // Monitor: busy window from the model, results popped from the scoreboard on done
  always @(negedge clk) begin
    exp_t e;
    chk("busy", 32'(bus.busy), 32'(ec >= busy_lo && ec <= busy_hi));
    if (bus.done === 1'b1) begin
      last_done = ec;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", ec, e.ec);
        chk("quot", bus.quot, e.q);
        chk("rem", bus.rem, e.r);
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
      end
    end
  end

  task automatic issue(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r);
    exp_t e;
    @(negedge clk);
    e.q   = q;
    e.r   = r;
    e.dbz = (b == '0);
    e.ec  = (b == '0) ? ec + 1 : ec + 34;
    if (b != '0) begin
      busy_lo = ec + 1;
      busy_hi = ec + 33;
    end
    sb.push_back(e);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.A         = a;
    bus.B         = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results pending after %0d cycles", sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_quot"}, bus.quot, 32'd0);
    chk({tag, "_rem"}, bus.rem, 32'd0);
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    repeat (3) @(negedge clk);
    // start coincident with reset must be dropped
    bus.start = 1'b1;
    bus.A     = 32'd9;
    bus.B     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b0;
    #1;
    chk_cleared("reset");

    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);                                  wait_done();
    issue(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);                wait_done();
    issue(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2);                     wait_done();
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);                wait_done();
    issue(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);                wait_done();
    issue(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);                              wait_done();
    issue(1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);                              wait_done();
    issue(1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB);                wait_done();

    // second start during CALC is ignored
    issue(1'b0, 32'd200, 32'd9, 32'd22, 32'd2);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'd1;
    bus.B     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("hold_quot", bus.quot, 32'd22);
    chk("hold_rem", bus.rem, 32'd2);

    // reset mid-operation discards the result
    issue(1'b0, 32'd50, 32'd3, 32'd16, 32'd2);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    busy_hi = ec;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_cleared("midreset");

    issue(1'b0, 32'd50, 32'd3, 32'd16, 32'd2);                                   wait_done();

    // back-to-back: next start in the cycle right after done
    issue(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF);                      wait_done();
    first_done = last_done;
    issue(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);                wait_done();
    chk("b2b_spacing", last_done - first_done, 32'd35);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
